// File: rtl/dcache_wb.sv
// dcache_wb: parametrised direct-mapped write-back data cache.
// Sits between the load/store unit and the memory serialiser. Misses run a
// victim writeback (if dirty) followed by a line fill, both over a narrow
// beat-serial memory port. A whole-cache flush writes back every dirty line.
//
// Ports:
//   clk, reset (async, active-low)
//   req/write/size/paddr/wdata -> ready/rdata   CPU access handshake
//   flush -> flush_done                          whole-cache writeback
//   mem_req/mem_write/mem_addr/mem_wdata         burst control and write beats
//   mem_wstrobe, mem_rdata/mem_rstrobe           memory beat handshakes
module dcache_wb #(
  parameter int RV          = 16,
  parameter int PA          = 22,
  parameter int LINE_LENGTH = 8,
  parameter int NLINES      = 8,
  parameter int MW          = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 req,
  input  logic                                 write,
  input  logic [1:0]                           size,
  input  logic [PA-1:0]                        paddr,
  input  logic [RV-1:0]                        wdata,
  output logic                                 ready,
  output logic [RV-1:0]                        rdata,
  input  logic                                 flush,
  output logic                                 flush_done,
  output logic                                 mem_req,
  output logic                                 mem_write,
  output logic [PA-$clog2(LINE_LENGTH)-1:0]    mem_addr,
  output logic [MW-1:0]                        mem_wdata,
  input  logic                                 mem_wstrobe,
  input  logic [MW-1:0]                        mem_rdata,
  input  logic                                 mem_rstrobe
);

  localparam int OFFW      = $clog2(LINE_LENGTH);
  localparam int IDXW      = $clog2(NLINES);
  localparam int TAGW      = PA - OFFW - IDXW;
  localparam int LINE_BITS = LINE_LENGTH * 8;
  localparam int BEATS     = LINE_BITS / MW;
  localparam int CNTW      = $clog2(BEATS);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WB         = 3'd1;
  localparam logic [2:0] S_FILL       = 3'd2;
  localparam logic [2:0] S_FLUSH_SCAN = 3'd3;
  localparam logic [2:0] S_FLUSH_WB   = 3'd4;

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BEATS - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [IDXW:0]   FIDX_ONE = (IDXW+1)'(1);

  logic [2:0]           state;
  logic [CNTW-1:0]      cnt;
  // Extra top bit marks "all lines scanned".
  logic [IDXW:0]        fidx;
  logic [NLINES-1:0]    valid;
  logic [NLINES-1:0]    dirty;
  logic [TAGW-1:0]      tag_mem  [NLINES];
  logic [LINE_BITS-1:0] data_mem [NLINES];

  logic [OFFW-1:0]      off;
  logic [IDXW-1:0]      pidx;
  logic [TAGW-1:0]      ptag;
  logic [IDXW-1:0]      fline;
  logic [IDXW-1:0]      bidx;
  logic                 hit;
  logic                 last_beat;
  logic [OFFW-1:0]      amask;
  logic [OFFW-1:0]      aoff;
  logic [OFFW+2:0]      bshift;
  logic [RV-1:0]        smask;
  logic [LINE_BITS-1:0] cur_line;
  logic [LINE_BITS-1:0] rd_line;
  logic [LINE_BITS-1:0] wr_line;
  logic [LINE_BITS-1:0] wr_mask;
  logic [LINE_BITS-1:0] wb_line;

  assign off       = paddr[OFFW-1:0];
  assign pidx      = paddr[OFFW +: IDXW];
  assign ptag      = paddr[PA-1 -: TAGW];
  assign fline     = fidx[IDXW-1:0];
  assign hit       = valid[pidx] && (tag_mem[pidx] == ptag);
  assign last_beat = (cnt == CNT_LAST);
  assign cur_line  = data_mem[pidx];

  // Align the offset down to the access size, then select/merge bytes.
  assign amask  = ~((OFFW'(1) << size) - OFFW'(1));
  assign aoff   = off & amask;
  assign bshift = {aoff, 3'b000};

  always_comb begin
    smask = '0;
    case (size)
      2'd0:    smask = RV'(8'hFF);
      2'd1:    smask = RV'(16'hFFFF);
      default: smask = '1;
    endcase
  end

  assign rd_line = cur_line >> bshift;
  assign wr_line = LINE_BITS'(wdata) << bshift;
  assign wr_mask = LINE_BITS'(smask) << bshift;

  assign ready = (state == S_IDLE) && req && !flush && hit;
  assign rdata = ready ? (rd_line[RV-1:0] & smask) : '0;

  assign flush_done = (state == S_FLUSH_SCAN) && fidx[IDXW];

  assign mem_req   = (state == S_WB) || (state == S_FILL) || (state == S_FLUSH_WB);
  assign mem_write = (state == S_WB) || (state == S_FLUSH_WB);
  assign bidx      = (state == S_FLUSH_WB) ? fline : pidx;
  assign wb_line   = data_mem[bidx];

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == S_FILL) begin
      mem_addr = {ptag, pidx};
    end else if (mem_write) begin
      mem_addr  = {tag_mem[bidx], bidx};
      mem_wdata = wb_line[cnt*MW +: MW];
    end
  end

  // Control state: reset clears everything that determines line validity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      fidx  <= '0;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (flush) begin
            state <= S_FLUSH_SCAN;
            fidx  <= '0;
          end else if (req && !hit) begin
            if (valid[pidx] && dirty[pidx]) begin
              state <= S_WB;
            end else begin
              valid[pidx] <= 1'b0;
              state       <= S_FILL;
            end
          end else if (ready && write) begin
            dirty[pidx] <= 1'b1;
          end
        end
        S_WB: begin
          if (mem_wstrobe) begin
            cnt <= cnt + CNT_ONE;
            if (last_beat) begin
              dirty[pidx] <= 1'b0;
              valid[pidx] <= 1'b0;
              cnt         <= '0;
              state       <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (mem_rstrobe) begin
            cnt <= cnt + CNT_ONE;
            if (last_beat) begin
              valid[pidx] <= 1'b1;
              dirty[pidx] <= 1'b0;
              cnt         <= '0;
              state       <= S_IDLE;
            end
          end
        end
        S_FLUSH_SCAN: begin
          if (fidx[IDXW]) begin
            state <= S_IDLE;
          end else if (valid[fline] && dirty[fline]) begin
            state <= S_FLUSH_WB;
          end else begin
            fidx <= fidx + FIDX_ONE;
          end
        end
        S_FLUSH_WB: begin
          if (mem_wstrobe) begin
            cnt <= cnt + CNT_ONE;
            if (last_beat) begin
              dirty[fline] <= 1'b0;
              cnt          <= '0;
              fidx         <= fidx + FIDX_ONE;
              state        <= S_FLUSH_SCAN;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (ready && write) begin
      data_mem[pidx] <= (cur_line & ~wr_mask) | (wr_line & wr_mask);
    end
    if ((state == S_FILL) && mem_rstrobe) begin
      data_mem[pidx][cnt*MW +: MW] <= mem_rdata;
      if (last_beat) begin
        tag_mem[pidx] <= ptag;
      end
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
module tb_dcache_wb;

  logic        clk;
  logic        reset;
  logic        req;
  logic        write;
  logic [1:0]  size;
  logic [21:0] paddr;
  logic [15:0] wdata;
  logic        ready;
  logic [15:0] rdata;
  logic        flush;
  logic        flush_done;
  logic        mem_req;
  logic        mem_write;
  logic [18:0] mem_addr;
  logic [3:0]  mem_wdata;
  logic        mem_wstrobe;
  logic [3:0]  mem_rdata;
  logic        mem_rstrobe;

  int checks = 0;
  int errors = 0;

  dcache_wb #(
    .RV(16),
    .PA(22),
    .LINE_LENGTH(8),
    .NLINES(8),
    .MW(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .write(write),
    .size(size),
    .paddr(paddr),
    .wdata(wdata),
    .ready(ready),
    .rdata(rdata),
    .flush(flush),
    .flush_done(flush_done),
    .mem_req(mem_req),
    .mem_write(mem_write),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrobe(mem_wstrobe),
    .mem_rdata(mem_rdata),
    .mem_rstrobe(mem_rstrobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Enter and return at a falling edge; beat k carries k ^ pat.
  task automatic fill_burst(input logic [18:0] addr, input int nbeats, input int gap,
                            input logic [3:0] pat);
    for (int k = 0; k < nbeats; k++) begin
      for (int g = 0; g < gap; g++) begin
        mem_rstrobe = 1'b0;
        #1;
        check("fill_stall_req", mem_req, 1);
        @(negedge clk);
      end
      mem_rstrobe = 1'b1;
      mem_rdata   = 4'(k) ^ pat;
      #1;
      check("fill_req", mem_req, 1);
      if (k == 0) begin
        check("fill_write", mem_write, 0);
        check("fill_addr", mem_addr, addr);
      end
      @(negedge clk);
      mem_rstrobe = 1'b0;
    end
  endtask

  task automatic wb_burst(input logic [18:0] addr, input logic [63:0] line);
    for (int k = 0; k < 16; k++) begin
      mem_wstrobe = 1'b1;
      #1;
      check("wb_req", mem_req, 1);
      check("wb_write", mem_write, 1);
      if (k == 0) check("wb_addr", mem_addr, addr);
      check("wb_wdata", mem_wdata, 4'(line >> (4*k)));
      @(negedge clk);
      mem_wstrobe = 1'b0;
    end
  endtask

  // Enter at a falling edge; return one time unit after one.
  task automatic wait_mem_req(input string tag);
    int n = 0;
    #1;
    while (!mem_req && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, mem_req, 1);
  endtask

  task automatic wait_flush_done(input string tag);
    int n = 0;
    #1;
    while (!flush_done && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, flush_done, 1);
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; write = 1'b0; size = 2'd0; paddr = '0; wdata = '0;
    flush = 1'b0; mem_wstrobe = 1'b0; mem_rdata = '0; mem_rstrobe = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_ready", ready, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_rdata", rdata, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Cold half load at 0x12 -> line 0x2, fill nibbles 0..F.
    req = 1'b1; write = 1'b0; size = 2'd1; paddr = 22'h000012;
    #1;
    check("cold_miss_ready", ready, 0);
    @(negedge clk);
    fill_burst(19'h2, 16, 0, 4'h0);
    #1;
    check("cold_req_drop", mem_req, 0);
    check("cold_ready", ready, 1);
    check("cold_rdata", rdata, 16'h7654);
    @(negedge clk);

    // Byte store hit, then read back byte and misaligned half.
    write = 1'b1; size = 2'd0; paddr = 22'h000013; wdata = 16'h00AB;
    #1;
    check("store_ready", ready, 1);
    check("store_no_mem", mem_req, 0);
    @(negedge clk);
    write = 1'b0;
    #1;
    check("ldb_ready", ready, 1);
    check("ldb_rdata", rdata, 16'h00AB);
    @(negedge clk);
    size = 2'd1;
    #1;
    check("ldh_misalign", rdata, 16'hAB54);
    @(negedge clk);

    // Dirty eviction: 0x50 maps to index 2 with tag 1.
    paddr = 22'h000050;
    #1;
    check("evict_miss", ready, 0);
    @(negedge clk);
    wb_burst(19'h2, 64'hFEDCBA98AB543210);
    fill_burst(19'hA, 16, 0, 4'h5);
    #1;
    check("evict_ready", ready, 1);
    check("evict_rdata", rdata, 16'h6745);
    @(negedge clk);
    req = 1'b0;

    // Make lines 1 and 5 dirty.
    req = 1'b1; write = 1'b1; size = 2'd1; paddr = 22'h000048; wdata = 16'h1234;
    @(negedge clk);
    fill_burst(19'h9, 16, 0, 4'h0);
    #1;
    check("st1_ready", ready, 1);
    @(negedge clk);
    size = 2'd0; paddr = 22'h00006F; wdata = 16'h00CD;
    @(negedge clk);
    fill_burst(19'hD, 16, 0, 4'h0);
    #1;
    check("st5_ready", ready, 1);
    @(negedge clk);
    req = 1'b0; write = 1'b0;

    // Flush: writebacks of line 1 then line 5, one flush_done.
    flush = 1'b1;
    wait_mem_req("flush_wb1_start");
    wb_burst(19'h9, 64'hFEDCBA9876541234);
    wait_mem_req("flush_wb5_start");
    wb_burst(19'hD, 64'hCDDCBA9876543210);
    wait_flush_done("flush_done_seen");
    flush = 1'b0;
    @(negedge clk);
    #1;
    check("flush_done_pulse", flush_done, 0);
    check("flush_idle_mem", mem_req, 0);
    @(negedge clk);
    req = 1'b1; size = 2'd1; paddr = 22'h000048;
    #1;
    check("reload1_ready", ready, 1);
    check("reload1_rdata", rdata, 16'h1234);
    check("reload1_nomem", mem_req, 0);
    @(negedge clk);
    size = 2'd0; paddr = 22'h00006F;
    #1;
    check("reload5_ready", ready, 1);
    check("reload5_rdata", rdata, 16'h00CD);
    @(negedge clk);
    req = 1'b0;

    // Reset after 8 of 16 fill beats.
    req = 1'b1; size = 2'd1; paddr = 22'h000018;
    @(negedge clk);
    fill_burst(19'h3, 8, 0, 4'h0);
    reset = 1'b0;
    #1;
    check("rstfill_mem_req", mem_req, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstfill_miss", ready, 0);
    @(negedge clk);
    fill_burst(19'h3, 16, 0, 4'h0);
    #1;
    check("refetch_req_drop", mem_req, 0);
    check("refetch_rdata", rdata, 16'h3210);
    @(negedge clk);

    // Dirty line 3, then flush and a conflicting req together.
    write = 1'b1; size = 2'd0; wdata = 16'h005A;
    #1;
    check("st3_ready", ready, 1);
    @(negedge clk);
    write = 1'b0; size = 2'd1; paddr = 22'h000058; flush = 1'b1;
    #1;
    check("contend_ready", ready, 0);
    @(negedge clk);
    wait_mem_req("contend_wb_start");
    wb_burst(19'h3, 64'hFEDCBA987654325A);
    wait_flush_done("contend_flush_done");
    flush = 1'b0;
    @(negedge clk);
    #1;
    check("contend_idle_mem", mem_req, 0);
    check("contend_miss", ready, 0);
    @(negedge clk);
    fill_burst(19'hB, 16, 2, 4'h0);
    #1;
    check("gap_req_drop", mem_req, 0);
    check("gap_ready", ready, 1);
    check("gap_rdata_lo", rdata, 16'h3210);
    @(negedge clk);
    paddr = 22'h00005E;
    #1;
    check("gap_rdata_hi", rdata, 16'hFEDC);
    @(negedge clk);
    req = 1'b0;
    #1;
    check("idle_rdata_zero", rdata, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Parametrised direct-mapped write-back data cache; successor to the fixed 16-bit/4-byte-line cache.
- Adds a CPU req/ready handshake, byte/half/word sizes and RV of 16 or 32.
- Adds an explicit miss FSM: victim writeback, then line fill over a narrow beat-serial memory port.
- Adds a whole-cache flush; sits between the load/store unit and the memory serialiser.

Parameters:
RV, 16, CPU data width (16 or 32)
PA, 22, physical address width
LINE_LENGTH, 8, line size in bytes (power of two, >= RV/8)
NLINES, 8, number of lines (power of two)
MW, 4, memory beat width in bits (4 or 8; BEATS = LINE_LENGTH*8/MW)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req  in  1  CPU access request; held with all request fields stable until ready
write  in  1  1 = store
size  in  2  0 byte, 1 half, 2 word (2 only when RV=32)
paddr  in  PA  byte address; misaligned low bits ignored (aligned down to size)
wdata  in  RV  store data, right-justified
ready  out  1  access complete this cycle
rdata  out  RV  load data, right-justified, zero-extended; 0 when !ready
flush  in  1  write back all dirty lines; held until flush_done
flush_done  out  1  one-cycle pulse when flush is complete
mem_req  out  1  burst active
mem_write  out  1  1 = writeback burst, 0 = fill burst
mem_addr  out  PA-log2(LINE_LENGTH)  line address of the burst
mem_wdata  out  MW  writeback beat
mem_wstrobe  in  1  memory consumed the current mem_wdata beat
mem_rdata  in  MW  fill beat
mem_rstrobe  in  1  mem_rdata valid this cycle

Behaviour:
- Address split: offset = paddr[log2(LINE_LENGTH)-1:0], index = next log2(NLINES) bits, tag = remaining upper bits.
- Line layout is little-endian. Beat k carries line bits [k*MW+MW-1 : k*MW], so beat 0 is the low nibble/byte of byte 0.
- Async reset clears: valid[], dirty[], state=IDLE, beat counter, flush index, and all outputs. Tag and data arrays are not reset.
- States: IDLE, WB, FILL, FLUSH_SCAN, FLUSH_WB.
- IDLE:
  - flush has priority over req; flush enters FLUSH_SCAN with index 0.
  - req with hit (valid && tag match): ready=1 combinationally the same cycle.
  - Load hit: rdata is driven the same cycle.
  - Store hit: merges the selected bytes at the clock edge and sets dirty.
  - req miss with victim valid && dirty: go to WB.
  - Any other miss: go to FILL.
- WB:
  - mem_req=1, mem_write=1, mem_addr = {victim tag, index}, mem_wdata = beat[cnt].
  - Each mem_wstrobe increments cnt.
  - On the last beat: clear dirty, cnt=0, go to FILL.
- FILL:
  - mem_req=1, mem_write=0, mem_addr = {ptag, index}.
  - Each mem_rstrobe writes beat[cnt] and increments cnt.
  - On the last beat: set tag=ptag, valid=1, dirty=0, cnt=0, go to IDLE. The held req then hits on the next cycle.
- Fill latency: miss → ready takes BEATS strobes (2*BEATS with writeback) plus one cycle.
- FLUSH_SCAN: each cycle examine line[fidx].
  - If valid && dirty: go to FLUSH_WB.
  - Otherwise fidx++.
  - After line NLINES-1: pulse flush_done, go to IDLE.
- FLUSH_WB: same as WB, but returns to FLUSH_SCAN with fidx++. Lines stay valid and become clean.
- ready is never asserted outside IDLE. A req arriving during a burst or flush waits.
- A strobe is ignored in any state that does not expect it.
- mem_req deasserts in the same cycle the final beat is taken.
- Reset mid-burst: mem_req drops asynchronously. The partially filled line stays invalid; the partially written-back line is invalid after reset.
- Counter wraps at BEATS-1; no partial bursts.

Test Plan:
- Cold load, refill (RV=16, MW=4, LINE_LENGTH=8, NLINES=8):
  - Stimulus: after reset, half load at paddr 0x000012; fill beats 0,1,…,F.
  - Required: mem_addr=0x000002, mem_write=0, exactly 16 beats; ready one cycle after the last strobe; rdata=0x7654.
- Byte store and read-back:
  - Stimulus: store byte 0xAB at 0x000013, then byte load at 0x000013.
  - Required: store gives ready in the request cycle with no mem_req; the load returns rdata=0x00AB.
- Dirty eviction:
  - Stimulus: load at 0x000050 (same index 2, tag 1).
  - Required: WB burst at mem_addr=0x000002 with mem_wdata 0,1,2,3,4,5,B,A,8,9,A,B,C,D,E,F; then a FILL burst at mem_addr=0x00000A.
- Flush:
  - Stimulus: dirty lines at indices 1 and 5 only; assert flush.
  - Required: two WB bursts in index order (1 then 5), then a single flush_done pulse; reloads of both lines hit with no mem_req.
- Reset mid-fill:
  - Stimulus: drop reset after beat 7.
  - Required: mem_req=0 immediately; after release the same load misses and refetches all 16 beats.
- Contention and stalls:
  - Stimulus: flush and req asserted together; mem_rstrobe gapped 1-in-3.
  - Required: flush completes first, then the req; fill data is identical to the ungapped case.
